// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared types and constants for the FPU add/sub arbiter.
// Provides the FSM state enum, channel id, latency counter type and IEEE-754 field helpers.
package fpu_arb_pkg;

    localparam int         SIGN_BIT = 31;
    localparam int         EXP_MSB  = 30;
    localparam int         EXP_LSB  = 23;
    localparam logic [7:0] EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef logic       chan_t;
    typedef logic [3:0] lat_cnt_t;

    // True for Inf/NaN encodings (all-ones exponent field).
    function automatic logic exp_is_max(input logic [31:0] f);
        return f[EXP_MSB:EXP_LSB] == EXP_MAX;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with a one-bit priority pointer.
// Ports: clk, rst (sync, active-high), en (grant allowed), req[1:0] in; gnt[1:0] one-hot out.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import fpu_arb_pkg::*;

    chan_t ptr;

    // A lone requester wins regardless of the pointer; the
    // pointer only breaks ties.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After a grant, priority passes to the other channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one add/sub FP datapath between two requesters, one op in flight.
// Ports: clk, n_rst (sync, active-high); req_valid/ready/op1/op2/sub per channel;
//        dp_op1/dp_op2 out, dp_result/dp_overflow in; rsp_valid/ready per channel;
//        rsp_result, rsp_ovf shared response bus; busy while not IDLE.
module fpu_arbiter #(
    parameter int LATENCY = 1,
    parameter int NCH     = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NCH-1:0]       req_valid,
    output logic [NCH-1:0]       req_ready,
    input  logic [NCH-1:0][31:0] req_op1,
    input  logic [NCH-1:0][31:0] req_op2,
    input  logic [NCH-1:0]       req_sub,
    output logic [31:0]          dp_op1,
    output logic [31:0]          dp_op2,
    input  logic [31:0]          dp_result,
    input  logic                 dp_overflow,
    output logic [NCH-1:0]       rsp_valid,
    input  logic [NCH-1:0]       rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_ovf,
    output logic                 busy
);
    import fpu_arb_pkg::*;

    localparam lat_cnt_t LAT_INIT = lat_cnt_t'(LATENCY - 1);

    state_t      state;
    state_t      next_state;
    lat_cnt_t    cnt;
    chan_t       chan;
    chan_t       gnt_chan;
    logic [1:0]  gnt;
    logic        arb_en;
    logic        take;
    logic        capture;
    logic        rsp_done;
    logic [31:0] op2_eff;

    // Grants are only possible in IDLE and never while reset is held,
    // so req_ready is low during reset.
    assign arb_en = (state == ST_IDLE) && !n_rst;

    rr_arb2 u_rr (
        .clk (clk),
        .rst (n_rst),
        .en  (arb_en),
        .req (req_valid),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign take      = |gnt;
    assign gnt_chan  = gnt[1];
    assign capture   = (state == ST_WAIT) && (cnt == '0);
    assign rsp_done  = (state == ST_RESP) && rsp_ready[chan];

    // Subtraction is an add with the second operand's sign flipped.
    always_comb begin
        op2_eff = req_op2[gnt_chan];
        op2_eff[SIGN_BIT] = op2_eff[SIGN_BIT] ^ req_sub[gnt_chan];
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (take)     next_state = ST_ISSUE;
            ST_ISSUE:               next_state = ST_WAIT;
            ST_WAIT:  if (capture)  next_state = ST_RESP;
            ST_RESP:  if (rsp_done) next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            cnt        <= '0;
            chan       <= 1'b0;
            dp_op1     <= '0;
            dp_op2     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
        end else begin
            if (take) begin
                chan   <= gnt_chan;
                dp_op1 <= req_op1[gnt_chan];
                dp_op2 <= op2_eff;
            end
            if (state == ST_ISSUE) begin
                cnt <= LAT_INIT;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - lat_cnt_t'(1);
            end
            if (capture) begin
                rsp_result      <= dp_result;
                rsp_ovf         <= dp_overflow | exp_is_max(dp_result);
                rsp_valid[chan] <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= '0;
            end
        end
    end

endmodule
